// File: rtl/pdm_pkg.sv
// Shared types and constants for the PDM record/playback controller.
package pdm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RECORD = 2'd2,
    ST_PLAY   = 2'd3
  } pdm_ctrl_state_t;

  localparam int PDM_SAMPLE_BITS = 8;
  localparam int PDM_CLK_HZ      = 100_000_000;
  localparam int PDM_PLAY_HZ     = 25_000;
  localparam int PDM_PLAY_DIV    = PDM_CLK_HZ / PDM_PLAY_HZ;

endpackage

// File: rtl/pdm_rate_tick.sv
// Free-running divider: one-cycle tick every DIV cycles, DIV cycles after a restart.
module pdm_rate_tick #(
  parameter int DIV = 4000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_r;
  logic          tick_r;

  // Counter and registered tick; the registered tick lands DIV cycles after restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= {CW{1'b0}};
      tick_r <= 1'b0;
    end else if (restart) begin
      cnt_r  <= {CW{1'b0}};
      tick_r <= 1'b0;
    end else begin
      tick_r <= (cnt_r == LAST);
      cnt_r  <= (cnt_r == LAST) ? {CW{1'b0}} : cnt_r + CW'(1'b1);
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/pdm_record_ctrl.sv
// PDM capture sequencer: settle, record into sample RAM, paced playback.
module pdm_record_ctrl
  import pdm_pkg::*;
#(
  parameter int SAMPLE_BITS    = PDM_SAMPLE_BITS,
  parameter int ADDR_BITS      = 4,
  parameter int SETTLE_SAMPLES = 16,
  parameter int PLAY_DIV       = PDM_PLAY_DIV
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_rec,
  input  logic                   start_play,
  input  logic                   stop,
  output logic                   mic_en,
  input  logic [SAMPLE_BITS-1:0] amplitude,
  input  logic                   amplitude_valid,
  output logic                   mem_we,
  output logic [ADDR_BITS-1:0]   mem_waddr,
  output logic [SAMPLE_BITS-1:0] mem_wdata,
  output logic                   mem_re,
  output logic [ADDR_BITS-1:0]   mem_raddr,
  input  logic [SAMPLE_BITS-1:0] mem_rdata,
  output logic [SAMPLE_BITS-1:0] play_data,
  output logic                   play_valid,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_BITS:0]     rec_len
);

  localparam int LEN_BITS = ADDR_BITS + 1;
  localparam int SET_BITS = (SETTLE_SAMPLES > 1) ? $clog2(SETTLE_SAMPLES) : 1;
  localparam logic [SET_BITS-1:0]  SETTLE_LAST = SET_BITS'(SETTLE_SAMPLES - 1);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR   = {ADDR_BITS{1'b1}};

  pdm_ctrl_state_t        state_r, state_n;
  logic [LEN_BITS-1:0]    rec_len_r, rec_len_n;
  logic [LEN_BITS-1:0]    rd_idx_r, rd_idx_n;
  logic [SET_BITS-1:0]    settle_cnt_r, settle_cnt_n;
  logic                   mem_we_r, mem_we_n, mem_re_r, mem_re_n;
  logic [ADDR_BITS-1:0]   mem_waddr_r, mem_waddr_n, mem_raddr_r, mem_raddr_n;
  logic [SAMPLE_BITS-1:0] mem_wdata_r, mem_wdata_n, play_data_r, play_data_n;
  logic                   play_valid_r, play_valid_n, done_r, done_n;
  logic                   busy_r, busy_n, mic_en_r, mic_en_n;
  logic                   restart_s, tick_s;

  pdm_rate_tick #(.DIV(PLAY_DIV)) u_play_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart_s),
    .tick    (tick_s)
  );

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    state_n      = state_r;
    rec_len_n    = rec_len_r;
    rd_idx_n     = rd_idx_r;
    settle_cnt_n = settle_cnt_r;
    mem_we_n     = 1'b0;
    mem_waddr_n  = mem_waddr_r;
    mem_wdata_n  = mem_wdata_r;
    mem_re_n     = 1'b0;
    mem_raddr_n  = mem_raddr_r;
    play_data_n  = play_data_r;
    play_valid_n = 1'b0;
    done_n       = 1'b0;
    restart_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_rec) begin
          rec_len_n    = {LEN_BITS{1'b0}};
          settle_cnt_n = {SET_BITS{1'b0}};
          state_n      = (SETTLE_SAMPLES == 0) ? ST_RECORD : ST_SETTLE;
        end else if (start_play) begin
          rd_idx_n  = {LEN_BITS{1'b0}};
          restart_s = 1'b1;
          state_n   = ST_PLAY;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (stop) begin
          state_n = ST_IDLE;
          done_n  = 1'b1;
        end else if (amplitude_valid && (settle_cnt_r == SETTLE_LAST)) begin
          state_n = ST_RECORD;
        end else if (amplitude_valid) begin
          settle_cnt_n = settle_cnt_r + SET_BITS'(1'b1);
        end else begin
          settle_cnt_n = settle_cnt_r;
        end
      end
      ST_RECORD: begin
        if (amplitude_valid) begin
          mem_we_n    = 1'b1;
          mem_waddr_n = rec_len_r[ADDR_BITS-1:0];
          mem_wdata_n = amplitude;
          rec_len_n   = rec_len_r + LEN_BITS'(1'b1);
        end else begin
          mem_we_n = 1'b0;
        end
        // Writing the last address ends the take; the index never wraps.
        if (stop || (amplitude_valid && (rec_len_r[ADDR_BITS-1:0] == LAST_ADDR))) begin
          state_n = ST_IDLE;
          done_n  = 1'b1;
        end else begin
          state_n = ST_RECORD;
        end
      end
      ST_PLAY: begin
        if (stop || (rec_len_r == {LEN_BITS{1'b0}})) begin
          state_n = ST_IDLE;
          done_n  = 1'b1;
        end else begin
          // Read data is taken at the edge that closes the mem_re cycle.
          if (mem_re_r) begin
            play_valid_n = 1'b1;
            play_data_n  = mem_rdata;
          end else begin
            play_valid_n = 1'b0;
          end
          if (mem_re_r && (rd_idx_r == rec_len_r)) begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
          end else begin
            state_n = ST_PLAY;
          end
          if (tick_s && (rd_idx_r != rec_len_r)) begin
            mem_re_n    = 1'b1;
            mem_raddr_n = rd_idx_r[ADDR_BITS-1:0];
            rd_idx_n    = rd_idx_r + LEN_BITS'(1'b1);
          end else begin
            mem_re_n = 1'b0;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
    busy_n   = (state_n != ST_IDLE);
    mic_en_n = (state_n == ST_SETTLE) || (state_n == ST_RECORD);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      rec_len_r    <= {LEN_BITS{1'b0}};
      rd_idx_r     <= {LEN_BITS{1'b0}};
      settle_cnt_r <= {SET_BITS{1'b0}};
      mem_we_r     <= 1'b0;
      mem_waddr_r  <= {ADDR_BITS{1'b0}};
      mem_wdata_r  <= {SAMPLE_BITS{1'b0}};
      mem_re_r     <= 1'b0;
      mem_raddr_r  <= {ADDR_BITS{1'b0}};
      play_data_r  <= {SAMPLE_BITS{1'b0}};
      play_valid_r <= 1'b0;
      done_r       <= 1'b0;
      busy_r       <= 1'b0;
      mic_en_r     <= 1'b0;
    end else begin
      state_r      <= state_n;
      rec_len_r    <= rec_len_n;
      rd_idx_r     <= rd_idx_n;
      settle_cnt_r <= settle_cnt_n;
      mem_we_r     <= mem_we_n;
      mem_waddr_r  <= mem_waddr_n;
      mem_wdata_r  <= mem_wdata_n;
      mem_re_r     <= mem_re_n;
      mem_raddr_r  <= mem_raddr_n;
      play_data_r  <= play_data_n;
      play_valid_r <= play_valid_n;
      done_r       <= done_n;
      busy_r       <= busy_n;
      mic_en_r     <= mic_en_n;
    end
  end

  assign mic_en     = mic_en_r;
  assign mem_we     = mem_we_r;
  assign mem_waddr  = mem_waddr_r;
  assign mem_wdata  = mem_wdata_r;
  assign mem_re     = mem_re_r;
  assign mem_raddr  = mem_raddr_r;
  assign play_data  = play_data_r;
  assign play_valid = play_valid_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign rec_len    = rec_len_r;

endmodule

// File: tb/tb_pdm_record_ctrl.sv
// Self-checking bench for pdm_record_ctrl: table vectors, random takes, corner sequences.
module tb_pdm_record_ctrl;

  localparam int SB = 8;
  localparam int AB = 4;
  localparam int SS = 2;
  localparam int PD = 10;
  localparam int DEPTH = 1 << AB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_rec = 1'b0, start_play = 1'b0, stop = 1'b0;
  logic [SB-1:0] amplitude = '0;
  logic          amplitude_valid = 1'b0;
  logic          mic_en, mem_we, mem_re, play_valid, busy, done;
  logic [AB-1:0] mem_waddr, mem_raddr;
  logic [SB-1:0] mem_wdata, mem_rdata, play_data;
  logic [AB:0]   rec_len;

  pdm_record_ctrl #(
    .SAMPLE_BITS(SB), .ADDR_BITS(AB), .SETTLE_SAMPLES(SS), .PLAY_DIV(PD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_rec(start_rec), .start_play(start_play), .stop(stop),
    .mic_en(mic_en), .amplitude(amplitude), .amplitude_valid(amplitude_valid),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .play_data(play_data), .play_valid(play_valid), .busy(busy), .done(done), .rec_len(rec_len)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Sample RAM: registered write, read data presented for the current read address.
  logic [SB-1:0] ram [0:DEPTH-1];
  always @(posedge clk) if (mem_we) ram[mem_waddr] <= mem_wdata;
  assign mem_rdata = ram[mem_raddr];

  // Output monitor, sampled on the inactive edge.
  int w_addr_q[$], w_data_q[$], w_cyc_q[$], p_data_q[$], p_cyc_q[$];
  int done_cnt = 0, done_cyc = 0, re_cnt = 0, rule_err = 0;
  always @(negedge clk) begin
    if (mem_we) begin w_addr_q.push_back(int'(mem_waddr)); w_data_q.push_back(int'(mem_wdata)); w_cyc_q.push_back(cyc); end
    if (play_valid) begin p_data_q.push_back(int'(play_data)); p_cyc_q.push_back(cyc); end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (mem_re) re_cnt++;
    if ((done && (busy || mic_en)) || (play_valid && mic_en)) rule_err++;
  end

  int checks = 0, fails = 0;
  int exp_val_q[$], exp_cyc_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clear_mon();
    w_addr_q.delete(); w_data_q.delete(); w_cyc_q.delete();
    p_data_q.delete(); p_cyc_q.delete();
    done_cnt = 0; re_cnt = 0;
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, int'({mic_en, mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr,
                    play_data, play_valid, busy, done, rec_len}), 0);
  endtask

  // mode 0: only a trailing stop; 1: stop the cycle after strobe 'at'; 2: stop with strobe 'at'.
  task automatic run_record(input int n, input int mode, input int at, input bit rnd, output int len);
    int seen, gap;
    bit ended, stop_now;
    clear_mon(); exp_val_q.delete(); exp_cyc_q.delete();
    seen = 0; ended = 1'b0;
    start_rec = 1'b1; step(); start_rec = 1'b0;
    for (int i = 1; i <= n; i++) begin
      gap = rnd ? int'($urandom_range(0, 2)) : 1;
      repeat (gap) step();
      amplitude       = rnd ? SB'($urandom) : SB'(i);
      amplitude_valid = 1'b1;
      stop_now        = (mode == 2) && (i == at);
      stop            = stop_now;
      if (!ended) begin
        if (stop_now && seen < SS) ended = 1'b1;
        else if (seen < SS) seen++;
        else begin
          exp_val_q.push_back(int'(amplitude)); exp_cyc_q.push_back(cyc + 1);
          if (exp_val_q.size() == DEPTH || stop_now) ended = 1'b1;
        end
      end
      step();
      amplitude_valid = 1'b0; stop = 1'b0;
      if (mode == 1 && i == at) begin
        stop = 1'b1; step(); stop = 1'b0;
        break;
      end
      if (stop_now) break;
    end
    stop = 1'b1; step(); stop = 1'b0;
    repeat (3) step();
    chk("wr_count", w_addr_q.size(), exp_val_q.size());
    for (int k = 0; k < exp_val_q.size() && k < w_addr_q.size(); k++) begin
      chk("wr_addr", w_addr_q[k], k);
      chk("wr_data", w_data_q[k], exp_val_q[k]);
      chk("wr_cycle", w_cyc_q[k], exp_cyc_q[k]);
    end
    chk("rec_len", int'(rec_len), exp_val_q.size());
    chk("rec_done_cnt", done_cnt, 1);
    chk("rec_idle", int'({busy, mic_en}), 0);
    len = int'(rec_len);
  endtask

  // Playback: samples at entry+PD+2, spaced PD; done with the last one (entry+1 if empty).
  task automatic run_play(input int n);
    int entry, t;
    clear_mon();
    start_play = 1'b1; entry = cyc + 1; step(); start_play = 1'b0;
    chk("play_mic_off", int'(mic_en), 0);
    t = 0;
    while (done_cnt == 0 && t < 400) begin step(); t++; end
    if (done_cnt == 0) chk("play_timeout", 0, 1);
    repeat (2) step();
    chk("play_count", p_data_q.size(), n);
    for (int i = 0; i < n && i < p_data_q.size(); i++) begin
      chk("play_data", p_data_q[i], exp_val_q[i]);
      chk("play_cycle", p_cyc_q[i], entry + PD + 2 + PD * i);
    end
    chk("play_done_cyc", done_cyc, (n == 0) ? entry + 1 : entry + PD + 2 + PD * (n - 1));
    chk("play_re_cnt", re_cnt, n);
    chk("play_done_cnt", done_cnt, 1);
  endtask

  typedef struct { int n; int mode; int at; int exp_len; } rec_vec_t;
  rec_vec_t vecs [5];

  initial begin
    int len;
    vecs[0] = '{n: 20, mode: 1, at: 7, exp_len: 5};
    vecs[1] = '{n: 20, mode: 0, at: 0, exp_len: 16};
    vecs[2] = '{n: 5,  mode: 2, at: 5, exp_len: 3};
    vecs[3] = '{n: 2,  mode: 1, at: 2, exp_len: 0};
    vecs[4] = '{n: 1,  mode: 2, at: 1, exp_len: 0};
    for (int i = 0; i < DEPTH; i++) ram[i] = '0;

    #2; chk_all_zero("reset_outputs");
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk_all_zero("post_reset_idle");

    // Stop issued the cycle after strobe 7, then playback of the five samples.
    run_record(20, 1, 7, 1'b0, len);
    chk("tp_rec_len_5", len, 5);
    run_play(5);

    // Stop in the mem_re cycle: that read is discarded.
    clear_mon();
    start_play = 1'b1; step(); start_play = 1'b0;
    for (int t = 0; t < 3 * PD && !mem_re; t++) step();
    chk("stop_play_re_seen", int'(mem_re), 1);
    stop = 1'b1; step(); stop = 1'b0;
    repeat (4) step();
    chk("stop_play_no_valid", p_data_q.size(), 0);
    chk("stop_play_done", done_cnt, 1);
    chk("stop_play_re_cnt", re_cnt, 1);

    // Both starts together: recording wins.
    clear_mon();
    start_rec = 1'b1; start_play = 1'b1; step(); start_rec = 1'b0; start_play = 1'b0;
    chk("both_start_mic_en", int'({mic_en, busy}), 3);
    repeat (2 * PD) step();
    chk("both_start_no_re", re_cnt, 0);
    stop = 1'b1; step(); stop = 1'b0; step();
    chk("both_start_done", done_cnt, 1);
    chk("both_start_len", int'(rec_len), 0);

    // Table of recording vectors, each followed by playback.
    for (int v = 0; v < 5; v++) begin
      run_record(vecs[v].n, vecs[v].mode, vecs[v].at, 1'b0, len);
      chk("vec_rec_len", len, vecs[v].exp_len);
      run_play(len);
    end

    // Randomized takes against the reference model.
    for (int it = 0; it < 6; it++) begin
      int n;
      n = int'($urandom_range(3, 24));
      run_record(n, int'($urandom_range(0, 2)), int'($urandom_range(1, n)), 1'b1, len);
      run_play(len);
    end

    // Asynchronous reset in the middle of a recording.
    start_rec = 1'b1; step(); start_rec = 1'b0;
    for (int i = 0; i < 5; i++) begin
      amplitude = SB'(40 + i); amplitude_valid = 1'b1; step();
    end
    #2 rst_n = 1'b0;
    #1 chk_all_zero("mid_record_reset");
    amplitude_valid = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    chk("reset_rec_len", int'(rec_len), 0);
    exp_val_q.delete();
    run_play(0);

    chk("rule_violations", rule_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
